// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one doubleword load/store,
// completes it after LATENCY clock edges and reports the result with a one-cycle response pulse.
`timescale 1ns/1ps

module data_mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [63:0] rdata,
   output logic        resp_err,
   output logic        stall
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [3:0]  r_count;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic        r_read;
   logic        r_write;
   logic [63:0] r_mem [DEPTH];

   logic        w_accept;
   logic        w_done;
   logic        w_err;
   logic [60:0] w_index;
   logic [AW-1:0] w_memIdx;

   assign w_accept = req_valid & req_ready & (req_read | req_write);
   assign w_done   = (r_state == BUSY) && (r_count == 4'd1);
   assign w_index  = r_addr[63:3];
   assign w_memIdx = w_index[AW-1:0];
   // Errors are judged on the captured request so inputs may change while busy.
   assign w_err    = (r_addr[2:0] != 3'd0) || (w_index >= 61'(DEPTH)) || (r_read && r_write);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = BUSY;
         BUSY:    if (r_count == 4'd1) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (r_state == IDLE);
      stall     = (r_state == BUSY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= 4'd0;
         r_addr  <= 64'd0;
         r_wdata <= 64'd0;
         r_read  <= 1'b0;
         r_write <= 1'b0;
      end else if (w_accept) begin
         r_count <= 4'(LATENCY);
         r_addr  <= addr;
         r_wdata <= wdata;
         r_read  <= req_read;
         r_write <= req_write;
      end else if (w_done) begin
         r_count <= 4'd0;
      end else if (r_state == BUSY) begin
         r_count <= r_count - 4'd1;
      end
   end

   // Storage is deliberately not reset; a reset during BUSY never reaches a completion edge.
   always_ff @(posedge clk) begin
      if (w_done && r_write && !w_err) r_mem[w_memIdx] <= r_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         rdata      <= 64'd0;
      end else begin
         resp_valid <= w_done;
         resp_err   <= w_done & w_err;
         if (w_done) begin
            if (w_err)       rdata <= 64'd0;
            else if (r_read) rdata <= r_mem[w_memIdx];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: randomized loads/stores compared against a
// word-addressed reference memory, plus handshake timing, error, reset and null-request scenarios.
`timescale 1ns/1ps

module tb_data_mem_responder;

   localparam int DEPTH   = 256;
   localparam int LATENCY = 3;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_read;
   logic        req_write;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [63:0] rdata;
   logic        resp_err;
   logic        stall;

   int vectors;
   int miscompares;

   // Reference model: sparse memory of words known to have been written, and the last rdata.
   logic [63:0] refMem [longint unsigned];
   logic [63:0] refRdata;
   longint unsigned knownIdx [$];

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_read(req_read),
      .req_write(req_write), .addr(addr), .wdata(wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .rdata(rdata), .resp_err(resp_err), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void modelTxn(input logic rd, input logic wr, input logic [63:0] a,
                                    input logic [63:0] d, output logic expErr,
                                    output logic [63:0] expRdata);
      longint unsigned idx;
      idx    = longint'(a >> 3);
      expErr = (a % 8 != 0) || (idx >= DEPTH) || (rd && wr);
      if (expErr)  refRdata = 64'd0;
      else if (rd) refRdata = refMem.exists(idx) ? refMem[idx] : 64'hx;
      else begin
         if (!refMem.exists(idx)) knownIdx.push_back(idx);
         refMem[idx] = d;
      end
      expRdata = refRdata;
   endfunction

   // Drives one request from IDLE and observes the following LATENCY+3 cycles.
   task automatic doTxn(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d,
                        output int stallCycles, output int respCycle, output int respCount,
                        output int errNoValid, output logic gotErr, output logic [63:0] gotRdata,
                        output logic gotReady);
      stallCycles = 0; respCycle = -1; respCount = 0; errNoValid = 0;
      gotErr = 1'bx; gotRdata = 64'hx; gotReady = 1'bx;
      @(negedge clk);
      req_valid = 1'b1; req_read = rd; req_write = wr; addr = a; wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
      addr = $urandom(); wdata = {$urandom(), $urandom()};
      for (int i = 0; i < LATENCY + 3; i++) begin
         @(negedge clk);
         if (stall) stallCycles++;
         if (resp_err && !resp_valid) errNoValid++;
         if (resp_valid) begin
            respCount++;
            if (respCycle < 0) begin
               respCycle = i; gotErr = resp_err; gotRdata = rdata; gotReady = req_ready;
            end
         end
      end
   endtask

   task automatic test_reset();
      req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; addr = '0; wdata = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      refRdata = 64'd0;
      @(negedge clk);
      vectors += 5;
      if (req_ready !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_ready got=%b exp=1", req_ready); end
      if (stall !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
      if (resp_valid !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      if (resp_err !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_resp_err got=%b exp=0", resp_err); end
      if (rdata !== 64'd0)      begin miscompares++; $display("[TB] FAIL reset_rdata got=%h exp=0", rdata); end
   endtask

   // Runs one transaction and checks timing, error flag and rdata against the model.
   task automatic test_txn(input string name, input logic rd, input logic wr,
                           input logic [63:0] a, input logic [63:0] d);
      int sc, rc, cnt, enl;
      logic ge, gr, expErr;
      logic [63:0] grd, expRd;
      modelTxn(rd, wr, a, d, expErr, expRd);
      doTxn(rd, wr, a, d, sc, rc, cnt, enl, ge, grd, gr);
      vectors += 7;
      if (sc !== LATENCY) begin miscompares++; $display("[TB] FAIL %s stall_cycles got=%0d exp=%0d", name, sc, LATENCY); end
      if (rc !== LATENCY) begin miscompares++; $display("[TB] FAIL %s resp_cycle got=%0d exp=%0d", name, rc, LATENCY); end
      if (cnt !== 1)      begin miscompares++; $display("[TB] FAIL %s resp_count got=%0d exp=1", name, cnt); end
      if (enl !== 0)      begin miscompares++; $display("[TB] FAIL %s err_without_valid got=%0d exp=0", name, enl); end
      if (ge !== expErr)  begin miscompares++; $display("[TB] FAIL %s resp_err got=%b exp=%b", name, ge, expErr); end
      if (grd !== expRd)  begin miscompares++; $display("[TB] FAIL %s rdata got=%h exp=%h", name, grd, expRd); end
      if (gr !== 1'b1)    begin miscompares++; $display("[TB] FAIL %s ready_in_resp got=%b exp=1", name, gr); end
   endtask

   task automatic test_store_load();
      longint unsigned idx;
      test_txn("store_0x10", 1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567);
      test_txn("load_0x10", 1'b1, 1'b0, 64'h10, 64'h0);
      test_txn("store_last", 1'b0, 1'b1, 64'((DEPTH - 1) * 8), {$urandom(), $urandom()});
      test_txn("store_first", 1'b0, 1'b1, 64'h0, {$urandom(), $urandom()});
      for (int i = 0; i < 12; i++) begin
         idx = longint'($urandom_range(0, DEPTH - 1));
         test_txn("rand_store", 1'b0, 1'b1, 64'(idx * 8), {$urandom(), $urandom()});
      end
      for (int i = 0; i < 16; i++) begin
         idx = knownIdx[$urandom_range(0, knownIdx.size() - 1)];
         test_txn("rand_load", 1'b1, 1'b0, 64'(idx * 8), {$urandom(), $urandom()});
      end
      test_txn("load_last", 1'b1, 1'b0, 64'((DEPTH - 1) * 8), 64'h0);
   endtask

   task automatic test_back_to_back();
      logic expErr;
      logic [63:0] expStoreRd, expLoadRd, d;
      int acceptEdge, firstResp;
      logic readyAtResp, prevStall;
      logic [63:0] secondRdata;
      int respSeen;
      d = {$urandom(), $urandom()};
      modelTxn(1'b0, 1'b1, 64'h40, d, expErr, expStoreRd);
      modelTxn(1'b1, 1'b0, 64'h40, 64'h0, expErr, expLoadRd);
      acceptEdge = -1; firstResp = -1; readyAtResp = 1'bx; secondRdata = 64'hx; respSeen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; addr = 64'h40; wdata = d;
      @(posedge clk);
      #1;
      req_read = 1'b1; req_write = 1'b0;
      prevStall = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            respSeen++;
            if (respSeen == 1) begin firstResp = i; readyAtResp = req_ready; end
            else secondRdata = rdata;
         end
         if (stall && !prevStall && acceptEdge < 0) begin
            acceptEdge = i;
            req_valid = 1'b0; req_read = 1'b0;
         end
         prevStall = stall;
      end
      req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
      vectors += 5;
      if (acceptEdge !== LATENCY + 1) begin miscompares++; $display("[TB] FAIL b2b_accept_edge got=%0d exp=%0d", acceptEdge, LATENCY + 1); end
      if (firstResp !== LATENCY)      begin miscompares++; $display("[TB] FAIL b2b_first_resp got=%0d exp=%0d", firstResp, LATENCY); end
      if (readyAtResp !== 1'b1)       begin miscompares++; $display("[TB] FAIL b2b_ready_in_resp got=%b exp=1", readyAtResp); end
      if (respSeen !== 2)             begin miscompares++; $display("[TB] FAIL b2b_resp_count got=%0d exp=2", respSeen); end
      if (secondRdata !== expLoadRd)  begin miscompares++; $display("[TB] FAIL b2b_load_rdata got=%h exp=%h", secondRdata, expLoadRd); end
   endtask

   task automatic test_errors();
      test_txn("store_0x20", 1'b0, 1'b1, 64'h20, 64'h0BAD_F00D_5555_AAAA);
      test_txn("load_misaligned", 1'b1, 1'b0, 64'h13, 64'h0);
      test_txn("load_out_of_range", 1'b1, 1'b0, 64'(8 * DEPTH), 64'h0);
      test_txn("store_misaligned", 1'b0, 1'b1, 64'h21, 64'hFFFF_FFFF_FFFF_FFFF);
      test_txn("store_out_of_range", 1'b0, 1'b1, 64'h8000_0000_0000_0020, 64'h1234);
      test_txn("store_read_write", 1'b1, 1'b1, 64'h20, 64'h7777_7777_7777_7777);
      test_txn("load_0x20_after_errs", 1'b1, 1'b0, 64'h20, 64'h0);
      test_txn("load_0x10_after_errs", 1'b1, 1'b0, 64'h10, 64'h0);
   endtask

   task automatic test_reset_midop();
      int respCount;
      logic stallAfter, readyAfter;
      test_txn("store_0x30_old", 1'b0, 1'b1, 64'h30, 64'hCAFE_0000_1111_2222);
      respCount = 0;
      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; addr = 64'h30; wdata = 64'h1;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      stallAfter = stall; readyAfter = req_ready;
      @(negedge clk);
      reset = 1'b0;
      refRdata = 64'd0;
      for (int i = 0; i < LATENCY + 3; i++) begin
         @(negedge clk);
         if (resp_valid) respCount++;
      end
      vectors += 3;
      if (stallAfter !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_stall got=%b exp=0", stallAfter); end
      if (readyAfter !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_ready got=%b exp=1", readyAfter); end
      if (respCount !== 0)     begin miscompares++; $display("[TB] FAIL midreset_resp_count got=%0d exp=0", respCount); end
      test_txn("load_0x30_after_reset", 1'b1, 1'b0, 64'h30, 64'h0);
   endtask

   task automatic test_null_request();
      int stallSeen, respSeen, notReady;
      stallSeen = 0; respSeen = 0; notReady = 0;
      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0; addr = 64'h18; wdata = 64'h5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (stall) stallSeen++;
         if (resp_valid) respSeen++;
         if (!req_ready) notReady++;
      end
      req_valid = 1'b0;
      vectors += 3;
      if (stallSeen !== 0) begin miscompares++; $display("[TB] FAIL null_stall got=%0d exp=0", stallSeen); end
      if (respSeen !== 0)  begin miscompares++; $display("[TB] FAIL null_resp got=%0d exp=0", respSeen); end
      if (notReady !== 0)  begin miscompares++; $display("[TB] FAIL null_ready_low got=%0d exp=0", notReady); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      refRdata = 64'd0;
      test_reset();
      test_store_load();
      test_back_to_back();
      test_errors();
      test_reset_midop();
      test_null_request();
      test_txn("final_load_0x40", 1'b1, 1'b0, 64'h40, 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
